// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store port responder with wait states, data RAM
// and unmapped-address flagging. All outputs are registered.
module data_mem_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  ack,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Counter preload; unused when there are no wait states.
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    // One extra bit so DEPTH == 2^ADDR_WIDTH compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic                    acc_we;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic                    commit;
    logic                    oor;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // State and wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one cycle of RESP.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_n = S_RESP;
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_n = S_RESP;
                else             cnt_n   = cnt - 4'd1;
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Capture the request at acceptance; later changes on the bus are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == S_IDLE && req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
        end
    end

    // With zero wait states the commit edge is the accept edge, so take the
    // live bus in IDLE and the latched copy otherwise.
    always_comb begin
        acc_we    = (state == S_IDLE) ? we    : lat_we;
        acc_addr  = (state == S_IDLE) ? addr  : lat_addr;
        acc_wdata = (state == S_IDLE) ? wdata : lat_wdata;
        // Gate with reset so nothing commits into RAM while reset is held.
        commit    = reset && (state_n == S_RESP);
        oor       = {1'b0, acc_addr} >= DEPTH_L;
    end

    // Registered handshake outputs and read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready <= 1'b1;
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= (state_n == S_IDLE);
            ack   <= commit;
            err   <= commit && oor;
            if (commit && !acc_we)
                rdata <= oor ? '0 : mem[acc_addr];
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && acc_we && !oor)
            mem[acc_addr] <= acc_wdata;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one instance with 2 wait states and DEPTH=200, one with
// zero wait states and full depth.
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       req_a = 1'b0, we_a = 1'b0;
    logic [7:0] addr_a = '0, wdata_a = '0;
    logic       ready_a, ack_a, err_a;
    logic [7:0] rdata_a;

    logic       req_b = 1'b0, we_b = 1'b0;
    logic [7:0] addr_b = '0, wdata_b = '0;
    logic       ready_b, ack_b, err_b;
    logic [7:0] rdata_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(2)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
        .ready(ready_a), .ack(ack_a), .err(err_a), .rdata(rdata_a)
    );

    data_mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .ready(ready_b), .ack(ack_b), .err(err_b), .rdata(rdata_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction on the 2-wait-state instance. With noise set, req/we/
    // addr/wdata are scrambled during WAIT and RESP.
    task automatic txn_a(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic noise, input logic exp_err, input logic [7:0] exp_rd);
        @(negedge clk);
        chk("ready_before", ready_a, 1);
        req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
        @(posedge clk);
        for (int k = 0; k <= 2; k++) begin
            @(negedge clk);
            if (k == 0) req_a = 1'b0;
            chk("ack_timing", ack_a, (k == 2) ? 1 : 0);
            chk("ready_busy", ready_a, 0);
            if (k == 2) begin
                chk("err", err_a, exp_err);
                chk("rdata", rdata_a, exp_rd);
            end
            if (noise) begin
                req_a = 1'b1; we_a = ~w; addr_a = 8'($urandom_range(0, 255)); wdata_a = ~d;
            end
        end
        @(negedge clk);
        req_a = 1'b0;
        chk("ack_after", ack_a, 0);
        chk("err_after", err_a, 0);
        chk("ready_after", ready_a, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_ready_a", ready_a, 1); chk("rst_ack_a", ack_a, 0);
        chk("rst_err_a", err_a, 0);     chk("rst_rdata_a", rdata_a, 8'h00);
        chk("rst_ready_b", ready_b, 1); chk("rst_ack_b", ack_b, 0);
        chk("rst_err_b", err_b, 0);     chk("rst_rdata_b", rdata_b, 8'h00);

        // Write then read with two wait states.
        txn_a(1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00);
        txn_a(1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'hA5);

        // Zero wait states, req held high across two requests.
        @(negedge clk);
        req_b = 1'b1; we_b = 1'b1; addr_b = 8'h00; wdata_b = 8'h3C;
        @(negedge clk);
        chk("ws0_wr_ack", ack_b, 1); chk("ws0_wr_ready", ready_b, 0); chk("ws0_wr_err", err_b, 0);
        we_b = 1'b0;
        @(negedge clk);
        chk("ws0_gap_ack", ack_b, 0); chk("ws0_gap_ready", ready_b, 1);
        @(negedge clk);
        chk("ws0_rd_ack", ack_b, 1); chk("ws0_rd_rdata", rdata_b, 8'h3C); chk("ws0_rd_err", err_b, 0);
        req_b = 1'b0;
        @(negedge clk);
        chk("ws0_idle_ack", ack_b, 0); chk("ws0_idle_ready", ready_b, 1);

        // Range boundary at DEPTH=200.
        txn_a(1'b1, 8'hC7, 8'h11, 1'b0, 1'b0, 8'hA5);
        txn_a(1'b1, 8'hC8, 8'h77, 1'b0, 1'b1, 8'hA5);
        txn_a(1'b0, 8'hC8, 8'h00, 1'b0, 1'b1, 8'h00);
        txn_a(1'b0, 8'hC7, 8'h00, 1'b0, 1'b0, 8'h11);

        // Reset during WAIT drops the pending write.
        txn_a(1'b1, 8'h20, 8'h99, 1'b0, 1'b0, 8'h11);
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h20; wdata_a = 8'h55;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0;
        chk("wait_ready", ready_a, 0);
        reset = 1'b0;
        #1;
        chk("abort_ready", ready_a, 1); chk("abort_ack", ack_a, 0); chk("abort_rdata", rdata_a, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_ack", ack_a, 0);
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_abort_no_ack", ack_a, 0);
        end
        txn_a(1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h99);

        // Bus noise while busy must not disturb the latched write.
        txn_a(1'b1, 8'h30, 8'h42, 1'b1, 1'b0, 8'h99);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("noise_no_ack", ack_a, 0);
        end
        txn_a(1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h42);

        // Asynchronous reset pulse between edges clears outputs at once.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("pulse_rdata_a", rdata_a, 8'h00); chk("pulse_ready_a", ready_a, 1);
        chk("pulse_ack_a", ack_a, 0);         chk("pulse_err_a", err_a, 0);
        chk("pulse_rdata_b", rdata_b, 8'h00); chk("pulse_ready_b", ready_b, 1);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("pulse_hold_ack", ack_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
